// File: rtl/pid_coeff_loader.sv
// Byte-serial loader for PID coefficients a0, a1, b0, b1, b2 with atomic shadow-to-active commit on the PID tick.
// Optional COEFF_READBACK_EN adds a registered byte readback port for the active coefficients.
module pid_coeff_loader #(
  parameter int unsigned REG_BITWIDTH = 32,
  parameter logic signed [REG_BITWIDTH-1:0] A0_INIT = '0,
  parameter logic signed [REG_BITWIDTH-1:0] A1_INIT = '0,
  parameter logic signed [REG_BITWIDTH-1:0] B0_INIT = '0,
  parameter logic signed [REG_BITWIDTH-1:0] B1_INIT = '0,
  parameter logic signed [REG_BITWIDTH-1:0] B2_INIT = '0
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           clk_en_i,
  input  logic                           pid_tick_i,
  input  logic                           cfg_start_i,
  input  logic [2:0]                     cfg_sel_i,
  input  logic [7:0]                     cfg_data_i,
  input  logic                           cfg_valid_i,
  output logic                           cfg_ready_o,
  input  logic                           commit_req_i,
  input  logic                           err_clr_i,
`ifdef COEFF_READBACK_EN
  input  logic [2:0]                     rd_sel_i,
  input  logic [((REG_BITWIDTH/8) > 1 ? $clog2(REG_BITWIDTH/8) : 1)-1:0] rd_byte_i,
  output logic [7:0]                     rd_data_o,
`endif
  output logic signed [REG_BITWIDTH-1:0] a0_o,
  output logic signed [REG_BITWIDTH-1:0] a1_o,
  output logic signed [REG_BITWIDTH-1:0] b0_o,
  output logic signed [REG_BITWIDTH-1:0] b1_o,
  output logic signed [REG_BITWIDTH-1:0] b2_o,
  output logic [4:0]                     dirty_o,
  output logic                           pending_o,
  output logic                           busy_o,
  output logic                           commit_done_o,
  output logic                           error_o
);

  localparam int unsigned NBYTES  = REG_BITWIDTH / 8;
  localparam int unsigned CNT_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned NCOEFF  = 5;
  localparam logic [REG_BITWIDTH-1:0] INIT [NCOEFF] = '{A0_INIT, A1_INIT, B0_INIT, B1_INIT, B2_INIT};

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sel_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [REG_BITWIDTH-1:0] shift_q;
  logic [REG_BITWIDTH-1:0] shadow_q [NCOEFF];
  logic [REG_BITWIDTH-1:0] active_q [NCOEFF];
  logic [4:0]              dirty_q;
  logic                    pending_q;
  logic                    commit_done_q;
  logic                    error_q;

  logic                    byte_acc;
  logic                    last_byte;
  logic                    start_ok;
  logic                    err_evt;
  logic                    commit_fire;
  logic [REG_BITWIDTH-1:0] word_next;

  // Event decode; everything is qualified by the clock enable
  assign byte_acc    = (state_q == LOAD) && clk_en_i && cfg_valid_i;
  assign last_byte   = byte_acc && (cnt_q == CNT_W'(NBYTES - 1));
  assign start_ok    = (state_q == IDLE) && clk_en_i && cfg_start_i && (cfg_sel_i < 3'd5);
  assign err_evt     = clk_en_i && cfg_start_i && ((state_q == LOAD) || (cfg_sel_i >= 3'd5));
  assign commit_fire = (state_q == IDLE) && clk_en_i && pid_tick_i && (pending_q || commit_req_i);
  assign word_next   = REG_BITWIDTH'({shift_q, cfg_data_i});

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD;
      LOAD:    if (last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; ready follows the enable so stalled cycles never consume a byte
  always_comb begin
    cfg_ready_o = 1'b0;
    busy_o      = 1'b0;
    if (state_q == LOAD) begin
      cfg_ready_o = clk_en_i;
      busy_o      = 1'b1;
    end
  end

  // Byte assembly
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (start_ok) begin
      sel_q   <= cfg_sel_i;
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_acc) begin
      shift_q <= word_next;
      cnt_q   <= last_byte ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Shadow, active and dirty registers; last byte and commit are mutually exclusive
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NCOEFF; i++) begin
        shadow_q[i] <= INIT[i];
        active_q[i] <= INIT[i];
      end
      dirty_q <= '0;
    end else if (commit_fire) begin
      for (int i = 0; i < NCOEFF; i++) active_q[i] <= shadow_q[i];
      dirty_q <= '0;
    end else if (last_byte) begin
      for (int i = 0; i < NCOEFF; i++) begin
        if (sel_q == 3'(i)) begin
          shadow_q[i] <= word_next;
          dirty_q[i]  <= 1'b1;
        end
      end
    end
  end

  // Commit request, done pulse and sticky error (error event beats clear)
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      commit_done_q <= commit_fire;
      if (commit_fire)                    pending_q <= 1'b0;
      else if (clk_en_i && commit_req_i)  pending_q <= 1'b1;
      if (err_evt)                        error_q <= 1'b1;
      else if (clk_en_i && err_clr_i)     error_q <= 1'b0;
    end
  end

`ifdef COEFF_READBACK_EN
  logic [REG_BITWIDTH-1:0] rd_word;
  logic [7:0]              rd_data_q;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NCOEFF; i++) begin
      if (rd_sel_i == 3'(i)) rd_word = active_q[i];
    end
  end

  // Readback runs every cycle, independent of the clock enable
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rd_data_q <= '0;
    else         rd_data_q <= 8'(rd_word >> (8 * (NBYTES - 1 - 32'(rd_byte_i))));
  end

  assign rd_data_o = rd_data_q;
`endif

  assign a0_o          = active_q[0];
  assign a1_o          = active_q[1];
  assign b0_o          = active_q[2];
  assign b1_o          = active_q[3];
  assign b2_o          = active_q[4];
  assign dirty_o       = dirty_q;
  assign pending_o     = pending_q;
  assign commit_done_o = commit_done_q;
  assign error_o       = error_q;

endmodule
